// File: rtl/hrm_pkg.sv
// hrm_pkg: constants shared across the HRM CPU I/O blocks.
//   HRM_DATA_W    - width of register R and of one queued I/O value
//   HRM_IO_ADDR_W - log2 depth of the inbox/outbox queues
//   HRM_OP_OUTBOX - opcode of the OUTBOX instruction (bench-side decoding)
package hrm_pkg;

  localparam int unsigned HRM_DATA_W    = 8;
  localparam int unsigned HRM_IO_ADDR_W = 5;
  localparam logic [3:0]  HRM_OP_OUTBOX = 4'b0001;

endpackage

// File: rtl/hrm_fifo_mem.sv
// hrm_fifo_mem: DEPTH x DATA_W storage for the HRM I/O queues.
// One synchronous write port, one asynchronous read port, no reset.
//   clk     - clock
//   we_i    - write enable
//   waddr_i - write address
//   wdata_i - write data
//   raddr_i - read address
//   rdata_o - read data (combinational from raddr_i)
module hrm_fifo_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hrm_outbox.sv
// hrm_outbox: first-word-fall-through output queue of the HRM CPU.
//   clk, i_rst  - clock, synchronous active-high reset
//   wO, i_data  - push strobe (ControlUnit OUTBOX state) and value of R
//   i_clear     - synchronous flush (storage untouched)
//   outFull     - queue holds DEPTH entries (ControlUnit stalls on it)
//   o_data      - head entry, 0 when nothing is valid
//   o_valid     - head entry available; i_ready - consumer takes head
//   o_empty     - queue holds 0 entries
//   o_count     - occupancy 0..DEPTH
//   o_overflow  - sticky: push attempted while full
module hrm_outbox
  import hrm_pkg::*;
#(
  parameter int unsigned DATA_W = HRM_DATA_W,
  parameter int unsigned ADDR_W = HRM_IO_ADDR_W
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              wO,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_clear,
  output logic              outFull,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow
);

  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, empty_q, valid_q, ovf_q, ovf_d;
  logic              push_ok, pop_ok, mem_we;
  logic [DATA_W-1:0] rd_data;

  // Both accept terms use only registered flags, so there is no
  // combinational path from wO/i_ready to outFull/o_valid.
  assign push_ok = wO & ~full_q;
  assign pop_ok  = valid_q & i_ready;
  assign mem_we  = push_ok & ~i_clear & ~i_rst;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (wO & full_q);
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end
  end

  // Flags are registered from the next count rather than decoded from
  // count_q, keeping them glitch-free and aligned with o_count.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_CNT);
      empty_q  <= (count_d == '0);
      valid_q  <= (count_d != '0);
      ovf_q    <= ovf_d;
    end
  end

  hrm_fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (i_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign outFull    = full_q;
  assign o_empty    = empty_q;
  assign o_valid    = valid_q;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;
  assign o_data     = valid_q ? rd_data : '0;

endmodule
